// File: rtl/wd_pkg.sv
// rtl/wd_pkg.sv - shared state encoding for the watchdog reset controller
package wd_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    WARN    = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } wd_state_e;

endpackage

// File: rtl/wd_dn_timer.sv
// rtl/wd_dn_timer.sv - loadable phase down-counter that stops at zero
module wd_dn_timer #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 zero_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Load wins over counting; the count parks at zero until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/watchdog_reset_ctrl.sv
// rtl/watchdog_reset_ctrl.sv - escalates a watchdog timeout into a warning irq and then a reset pulse
module watchdog_reset_ctrl
  import wd_pkg::*;
#(
  parameter int CNT_WIDTH      = 5,
  parameter int GRACE_CYCLES   = 8,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TOCNT_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   timeout,
  input  logic                   irq_ack,
  output logic                   wd_irq,
  output logic                   sys_rst,
  output logic [STATE_W-1:0]     state,
  output logic [TOCNT_WIDTH-1:0] timeout_cnt
);

  // Each phase length must be loadable into the timer as length-1.
  if (GRACE_CYCLES < 1 || GRACE_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_grace
    $error("GRACE_CYCLES out of range for CNT_WIDTH");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_pulse
    $error("PULSE_CYCLES out of range for CNT_WIDTH");
  end
  if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] GRACE_LD   = CNT_WIDTH'(GRACE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LD   = CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLDOFF_LD = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

  wd_state_e              state_q, state_d;
  logic                   timeout_d_q;
  logic                   wd_irq_q, sys_rst_q;
  logic [TOCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   tmr_load;
  logic [CNT_WIDTH-1:0]   tmr_load_val;
  logic                   tmr_zero;

  wd_dn_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // Next state, timer loads and the saturating escalation count.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (timeout && !timeout_d_q) begin
          state_d      = WARN;
          tmr_load     = 1'b1;
          tmr_load_val = GRACE_LD;
        end
      end
      WARN: begin
        if (irq_ack) begin
          state_d = IDLE;
        end else if (tmr_zero) begin
          state_d      = PULSE;
          tmr_load     = 1'b1;
          tmr_load_val = PULSE_LD;
          if (cnt_q != '1) cnt_d = cnt_q + TOCNT_WIDTH'(1);
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d      = HOLDOFF;
          tmr_load     = 1'b1;
          tmr_load_val = HOLDOFF_LD;
        end
      end
      HOLDOFF: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge-detect history and outputs decoded from the next state so they track state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timeout_d_q <= 1'b0;
      wd_irq_q    <= 1'b0;
      sys_rst_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      timeout_d_q <= timeout;
      wd_irq_q    <= (state_d == WARN);
      sys_rst_q   <= (state_d == PULSE);
      cnt_q       <= cnt_d;
    end
  end

  assign wd_irq      = wd_irq_q;
  assign sys_rst     = sys_rst_q;
  assign state       = state_q;
  assign timeout_cnt = cnt_q;

endmodule
